// File: rtl/derm_input_pingpong_buffer.sv
// derm_input_pingpong_buffer: two-bank multi-lane ping-pong buffer handed between writer and reader by commit/release.
module derm_input_pingpong_buffer #(
    parameter int DATA_W    = 48,
    parameter int ADDR_W    = 11,
    parameter int NUM_USERS = 16
) (
    input  logic                          i_core_clk,
    input  logic                          i_rx_rst,
    input  logic [ADDR_W-1:0]             i_wr_addr,
    input  logic [DATA_W*NUM_USERS-1:0]   i_wr_data,
    input  logic [NUM_USERS-1:0]          i_wr_en,
    input  logic                          i_wr_commit,
    input  logic [ADDR_W:0]               i_wr_len,
    output logic                          o_wr_ready,
    output logic                          o_wr_drop,
    input  logic [ADDR_W-1:0]             i_rd_addr,
    input  logic                          i_rd_en,
    input  logic                          i_rd_release,
    output logic                          o_rd_avail,
    output logic [ADDR_W:0]               o_rd_len,
    output logic [DATA_W*NUM_USERS-1:0]   o_rd_data,
    output logic                          o_rd_valid,
    output logic [1:0]                    o_full_banks
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic            wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [1:0]      full_q, full_d;
    logic [ADDR_W:0] len_q [2];
    logic [ADDR_W:0] len_d [2];
    logic            wr_drop_q, wr_drop_d, rd_valid_q, rd_valid_d;
    logic [1:0]      full_banks_q, full_banks_d;
    logic            wr_ready, rd_avail, do_commit, do_release, rd_fire;
    always_comb begin
        wr_ready     = ~full_q[wr_bank_q];
        rd_avail     = full_q[rd_bank_q];
        do_commit    = i_wr_commit & wr_ready;
        do_release   = i_rd_release & rd_avail;
        rd_fire      = i_rd_en & rd_avail;
        full_d       = full_q;
        len_d        = len_q;
        if (do_commit) begin
            full_d[wr_bank_q] = 1'b1;
            len_d[wr_bank_q]  = i_wr_len;
        end
        // commit and release can never target the same bank, so order is irrelevant
        if (do_release)
            full_d[rd_bank_q] = 1'b0;
        wr_bank_d    = wr_bank_q ^ do_commit;
        rd_bank_d    = rd_bank_q ^ do_release;
        wr_drop_d    = (|i_wr_en | i_wr_commit) & ~wr_ready;
        rd_valid_d   = rd_fire;
        full_banks_d = {1'b0, full_d[0]} + {1'b0, full_d[1]};
    end
    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            full_q       <= '0;
            len_q[0]     <= '0;
            len_q[1]     <= '0;
            wr_drop_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            full_banks_q <= '0;
        end else begin
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            full_q       <= full_d;
            len_q        <= len_d;
            wr_drop_q    <= wr_drop_d;
            rd_valid_q   <= rd_valid_d;
            full_banks_q <= full_banks_d;
        end
    end
    for (genvar u = 0; u < NUM_USERS; u++) begin : g_lane
        logic [DATA_W-1:0] mem [2*DEPTH];
        logic [DATA_W-1:0] rd_data_q;
        always_ff @(posedge i_core_clk) begin
            if (!i_rx_rst && wr_ready && i_wr_en[u])
                mem[{wr_bank_q, i_wr_addr}] <= i_wr_data[u*DATA_W +: DATA_W];
        end
        // read register holds its last word when no read fires
        always_ff @(posedge i_core_clk) begin
            if (i_rx_rst)
                rd_data_q <= '0;
            else if (rd_fire)
                rd_data_q <= mem[{rd_bank_q, i_rd_addr}];
        end
        assign o_rd_data[u*DATA_W +: DATA_W] = rd_data_q;
    end
    assign o_wr_ready   = wr_ready;
    assign o_wr_drop    = wr_drop_q;
    assign o_rd_avail   = rd_avail;
    assign o_rd_len     = len_q[rd_bank_q];
    assign o_rd_valid   = rd_valid_q;
    assign o_full_banks = full_banks_q;
endmodule
